// File: rtl/pipe_control.sv
// Pipelined control for the 5-stage RV32I core: decodes the D-stage instruction and
// carries its control through D/E/M/W, resolving branches/jumps and load-use hazards in E.
module pipe_control #(
   parameter int ALUCTRL_W = 4,
   parameter int RA_W      = 5
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 instr_valid_d,
   input  logic [6:0]           op_d,
   input  logic [2:0]           funct3_d,
   input  logic                 funct75_d,
   input  logic [RA_W-1:0]      rs1_d,
   input  logic [RA_W-1:0]      rs2_d,
   input  logic [RA_W-1:0]      rd_d,
   input  logic                 zero_e,
   input  logic                 lt_e,
   input  logic                 ltu_e,
   output logic [2:0]           immsrc_d,
   output logic                 illegal_d,
   output logic                 stall_f,
   output logic                 stall_d,
   output logic                 flush_d,
   output logic                 flush_e,
   output logic                 alusrc_e,
   output logic [ALUCTRL_W-1:0] alucontrol_e,
   output logic                 pcsrc_e,
   output logic                 jalr_e,
   output logic                 memwrite_m,
   output logic                 regwrite_m,
   output logic [RA_W-1:0]      rd_m,
   output logic                 regwrite_w,
   output logic [1:0]           resultsrc_w,
   output logic [RA_W-1:0]      rd_w
);

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;

   typedef enum logic [3:0] {
      ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLT,
      ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA, ALU_PASSB
   } alu_op_e;

   typedef struct packed {
      logic                 valid;
      logic                 regwrite;
      logic [1:0]           resultsrc;
      logic                 memwrite;
      logic                 branch;
      logic                 jump;
      logic                 jalr;
      logic                 load;
      logic                 alusrc;
      logic [ALUCTRL_W-1:0] alucontrol;
      logic [2:0]           funct3;
      logic [RA_W-1:0]      rd;
   } ctrl_e_t;

   // A bubble has every enable at zero, so M/W need no valid bit of their own.
   typedef struct packed {
      logic            regwrite;
      logic [1:0]      resultsrc;
      logic            memwrite;
      logic [RA_W-1:0] rd;
   } ctrl_m_t;

   typedef struct packed {
      logic            regwrite;
      logic [1:0]      resultsrc;
      logic [RA_W-1:0] rd;
   } ctrl_w_t;

   function automatic alu_op_e arith_op(input logic [2:0] f3, input logic f75, input logic is_r);
      case (f3)
         3'b000: if (is_r && f75) arith_op = ALU_SUB; else arith_op = ALU_ADD;
         3'b001: arith_op = ALU_SLL;
         3'b010: arith_op = ALU_SLT;
         3'b011: arith_op = ALU_SLTU;
         3'b100: arith_op = ALU_XOR;
         3'b101: if (f75) arith_op = ALU_SRA; else arith_op = ALU_SRL;
         3'b110: arith_op = ALU_OR;
         default: arith_op = ALU_AND;
      endcase
   endfunction

   ctrl_e_t dec, ex;
   ctrl_m_t mem;
   ctrl_w_t wb;
   alu_op_e alu;
   logic    illegal, rs1_used, rs2_used, cond, load_use;

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can infer a latch.
      dec      = '0;
      alu      = ALU_ADD;
      immsrc_d = 3'b000;
      illegal  = 1'b0;
      rs1_used = 1'b0;
      rs2_used = 1'b0;
      if (instr_valid_d) begin
         case (op_d)
            OP_R: begin
               dec.regwrite = 1'b1;
               alu          = arith_op(funct3_d, funct75_d, 1'b1);
               rs1_used     = 1'b1;
               rs2_used     = 1'b1;
            end
            OP_I: begin
               dec.regwrite = 1'b1;
               dec.alusrc   = 1'b1;
               alu          = arith_op(funct3_d, funct75_d, 1'b0);
               rs1_used     = 1'b1;
            end
            OP_LOAD: begin
               dec.regwrite  = 1'b1;
               dec.resultsrc = 2'b01;
               dec.load      = 1'b1;
               dec.alusrc    = 1'b1;
               rs1_used      = 1'b1;
            end
            OP_STORE: begin
               dec.memwrite = 1'b1;
               dec.alusrc   = 1'b1;
               immsrc_d     = 3'b001;
               rs1_used     = 1'b1;
               rs2_used     = 1'b1;
            end
            OP_BRANCH: begin
               if (funct3_d[2:1] == 2'b01) begin
                  illegal = 1'b1;
               end else begin
                  dec.branch = 1'b1;
                  alu        = ALU_SUB;
                  immsrc_d   = 3'b010;
                  rs1_used   = 1'b1;
                  rs2_used   = 1'b1;
               end
            end
            OP_JAL: begin
               dec.regwrite  = 1'b1;
               dec.resultsrc = 2'b10;
               dec.jump      = 1'b1;
               immsrc_d      = 3'b011;
            end
            OP_JALR: begin
               dec.regwrite  = 1'b1;
               dec.resultsrc = 2'b10;
               dec.jump      = 1'b1;
               dec.jalr      = 1'b1;
               dec.alusrc    = 1'b1;
               rs1_used      = 1'b1;
            end
            OP_LUI: begin
               dec.regwrite = 1'b1;
               dec.alusrc   = 1'b1;
               alu          = ALU_PASSB;
               immsrc_d     = 3'b100;
            end
            default: illegal = 1'b1;
         endcase
         if (!illegal) begin
            dec.valid      = 1'b1;
            dec.alucontrol = ALUCTRL_W'(alu);
            dec.funct3     = funct3_d;
            dec.rd         = rd_d;
         end
      end
      illegal_d = illegal;
   end

   always_comb begin
      case (ex.funct3)
         3'b000:  cond = zero_e;
         3'b001:  cond = ~zero_e;
         3'b100:  cond = lt_e;
         3'b101:  cond = ~lt_e;
         3'b110:  cond = ltu_e;
         3'b111:  cond = ~ltu_e;
         default: cond = 1'b0;
      endcase
   end

   assign pcsrc_e  = ex.valid & (ex.jump | (ex.branch & cond));
   assign load_use = ex.valid & ex.load & (ex.rd != '0) &
                     (((ex.rd == rs1_d) & rs1_used) | ((ex.rd == rs2_d) & rs2_used));

   // A redirect squashes D anyway, so it overrides a coincident stall.
   assign stall_f = load_use & ~pcsrc_e;
   assign stall_d = load_use & ~pcsrc_e;
   assign flush_d = pcsrc_e;
   assign flush_e = pcsrc_e | load_use;

   // NOTE: pipeline state uses non-blocking assignments so each stage samples the old value of the previous one.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex  <= '0;
         mem <= '0;
         wb  <= '0;
      end else begin
         ex  <= flush_e ? '0 : dec;
         mem <= '{regwrite: ex.regwrite, resultsrc: ex.resultsrc, memwrite: ex.memwrite, rd: ex.rd};
         wb  <= '{regwrite: mem.regwrite, resultsrc: mem.resultsrc, rd: mem.rd};
      end
   end

   assign alusrc_e     = ex.alusrc;
   assign alucontrol_e = ex.alucontrol;
   assign jalr_e       = ex.jalr;
   assign memwrite_m   = mem.memwrite;
   assign regwrite_m   = mem.regwrite;
   assign rd_m         = mem.rd;
   assign regwrite_w   = wb.regwrite;
   assign resultsrc_w  = wb.resultsrc;
   assign rd_w         = wb.rd;

endmodule

// File: tb/tb_pipe_control.sv
// Bench for pipe_control: acts as the datapath (F/D register, instruction stream, ALU flags)
// and compares every control output each cycle against an instruction-level reference model.
module tb_pipe_control;

   localparam int ALUCTRL_W = 4;
   localparam int RA_W      = 5;

   localparam bit [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LD = 7'b0000011,
                        OP_ST = 7'b0100011, OP_BR = 7'b1100011, OP_JAL = 7'b1101111,
                        OP_JALR = 7'b1100111, OP_LUI = 7'b0110111;

   // ALUControl for each funct3 of the plain (non-sub, non-sra) arithmetic forms.
   localparam int ARITH [8] = '{0, 7, 5, 6, 4, 8, 3, 2};

   logic                 clk, rst_n, instr_valid_d, funct75_d, zero_e, lt_e, ltu_e;
   logic [6:0]           op_d;
   logic [2:0]           funct3_d, immsrc_d;
   logic [RA_W-1:0]      rs1_d, rs2_d, rd_d, rd_m, rd_w;
   logic                 illegal_d, stall_f, stall_d, flush_d, flush_e, alusrc_e, pcsrc_e, jalr_e;
   logic [ALUCTRL_W-1:0] alucontrol_e;
   logic                 memwrite_m, regwrite_m, regwrite_w;
   logic [1:0]           resultsrc_w;

   pipe_control #(.ALUCTRL_W(ALUCTRL_W), .RA_W(RA_W)) dut (
      .clk(clk), .rst_n(rst_n), .instr_valid_d(instr_valid_d), .op_d(op_d),
      .funct3_d(funct3_d), .funct75_d(funct75_d), .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d),
      .zero_e(zero_e), .lt_e(lt_e), .ltu_e(ltu_e), .immsrc_d(immsrc_d), .illegal_d(illegal_d),
      .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d), .flush_e(flush_e),
      .alusrc_e(alusrc_e), .alucontrol_e(alucontrol_e), .pcsrc_e(pcsrc_e), .jalr_e(jalr_e),
      .memwrite_m(memwrite_m), .regwrite_m(regwrite_m), .rd_m(rd_m),
      .regwrite_w(regwrite_w), .resultsrc_w(resultsrc_w), .rd_w(rd_w)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit       valid;
      bit [6:0] op;
      bit [2:0] f3;
      bit       f75;
      bit [4:0] rs1, rs2, rd;
   } ins_t;

   typedef struct {
      bit       valid, illegal, rw, mw, asrc, jump, jalr, br, load, u1, u2;
      bit [2:0] imm, f3;
      bit [1:0] rsrc;
      bit [3:0] alu;
      bit [4:0] rd;
   } exp_t;

   int   checks = 0;
   int   errors = 0;
   ins_t fd;
   ins_t fetchq[$];
   exp_t e_m, m_m, w_m;
   exp_t bub = '{default: 0};
   bit   zf, ltf, ltuf, rand_flags;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic ins_t mk(bit [6:0] op, bit [2:0] f3, bit f75, int rd, int rs1, int rs2);
      ins_t i;
      i.valid = 1'b1; i.op = op; i.f3 = f3; i.f75 = f75;
      i.rd = 5'(rd); i.rs1 = 5'(rs1); i.rs2 = 5'(rs2);
      return i;
   endfunction

   // What the instruction means to the pipeline, straight from the ISA subset rules.
   function automatic exp_t model(ins_t i);
      exp_t x = '{default: 0};
      bit   bad = 1'b0;
      if (!i.valid) return x;
      x.valid = 1'b1; x.f3 = i.f3; x.rd = i.rd;
      case (i.op)
         OP_R: begin
            x.rw = 1; x.u1 = 1; x.u2 = 1;
            x.alu = (i.f3 == 0 && i.f75) ? 4'd1 : (i.f3 == 5 && i.f75) ? 4'd9 : 4'(ARITH[i.f3]);
         end
         OP_I: begin
            x.rw = 1; x.asrc = 1; x.u1 = 1;
            x.alu = (i.f3 == 5 && i.f75) ? 4'd9 : 4'(ARITH[i.f3]);
         end
         OP_LD:   begin x.rw = 1; x.rsrc = 1; x.load = 1; x.asrc = 1; x.u1 = 1; end
         OP_ST:   begin x.mw = 1; x.asrc = 1; x.u1 = 1; x.u2 = 1; x.imm = 1; end
         OP_BR:   if (i.f3 == 2 || i.f3 == 3) bad = 1;
                  else begin x.br = 1; x.alu = 1; x.u1 = 1; x.u2 = 1; x.imm = 2; end
         OP_JAL:  begin x.rw = 1; x.rsrc = 2; x.jump = 1; x.imm = 3; end
         OP_JALR: begin x.rw = 1; x.rsrc = 2; x.jump = 1; x.jalr = 1; x.asrc = 1; x.u1 = 1; end
         OP_LUI:  begin x.rw = 1; x.asrc = 1; x.alu = 10; x.imm = 4; end
         default: bad = 1;
      endcase
      if (bad) begin
         x = '{default: 0};
         x.illegal = 1;
      end
      return x;
   endfunction

   function automatic bit taken(bit [2:0] f3);
      case (f3)
         0: return zf;
         1: return !zf;
         4: return ltf;
         5: return !ltf;
         6: return ltuf;
         7: return !ltuf;
         default: return 0;
      endcase
   endfunction

   function automatic ins_t rand_ins();
      bit [6:0] ops [10] = '{OP_R, OP_I, OP_LD, OP_ST, OP_BR, OP_JAL, OP_JALR, OP_LUI,
                             7'b1111111, 7'b0001011};
      ins_t i = mk(ops[$urandom_range(0, 9)], 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                   $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
      i.valid = ($urandom_range(0, 9) != 0);
      return i;
   endfunction

   // One clock cycle: starts 1 time unit after a rising edge, checks at the falling edge.
   task automatic step();
      exp_t ed;
      ins_t nxt;
      bit   pc, lu;
      if (rand_flags) begin
         zf = 1'($urandom_range(0, 1)); ltf = 1'($urandom_range(0, 1)); ltuf = 1'($urandom_range(0, 1));
      end
      instr_valid_d = fd.valid; op_d = fd.op; funct3_d = fd.f3; funct75_d = fd.f75;
      rs1_d = fd.rs1; rs2_d = fd.rs2; rd_d = fd.rd;
      zero_e = zf; lt_e = ltf; ltu_e = ltuf;
      @(negedge clk);
      ed = model(fd);
      pc = e_m.valid && (e_m.jump || (e_m.br && taken(e_m.f3)));
      lu = e_m.valid && e_m.load && e_m.rd != 0 &&
           ((e_m.rd == fd.rs1 && ed.u1) || (e_m.rd == fd.rs2 && ed.u2));
      check("immsrc_d", 32'(immsrc_d), 32'(ed.imm));
      check("illegal_d", 32'(illegal_d), 32'(ed.illegal));
      check("stall_f", 32'(stall_f), 32'(lu && !pc));
      check("stall_d", 32'(stall_d), 32'(lu && !pc));
      check("flush_d", 32'(flush_d), 32'(pc));
      check("flush_e", 32'(flush_e), 32'(pc || lu));
      check("pcsrc_e", 32'(pcsrc_e), 32'(pc));
      check("jalr_e", 32'(jalr_e), 32'(e_m.jalr));
      if (e_m.valid) begin
         check("alusrc_e", 32'(alusrc_e), 32'(e_m.asrc));
         check("alucontrol_e", 32'(alucontrol_e), 32'(e_m.alu));
      end
      check("memwrite_m", 32'(memwrite_m), 32'(m_m.mw));
      check("regwrite_m", 32'(regwrite_m), 32'(m_m.rw));
      if (m_m.rw) check("rd_m", 32'(rd_m), 32'(m_m.rd));
      check("regwrite_w", 32'(regwrite_w), 32'(w_m.rw));
      if (w_m.valid) check("resultsrc_w", 32'(resultsrc_w), 32'(w_m.rsrc));
      if (w_m.rw) check("rd_w", 32'(rd_w), 32'(w_m.rd));
      w_m = m_m;
      m_m = e_m;
      e_m = (pc || lu) ? bub : ed;
      if (!(lu && !pc)) begin
         nxt = (fetchq.size() != 0) ? fetchq.pop_front() : '{default: 0};
         fd  = pc ? '{default: 0} : nxt;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      int n = 0;
      while ((fetchq.size() != 0 || fd.valid) && n < 5000) begin
         step();
         n++;
      end
      check("drain_bound", 32'(fetchq.size() != 0 || fd.valid), 32'd0);
      repeat (4) step();
   endtask

   // Asserts reset between edges and checks the pipeline empties without a clock edge.
   task automatic apply_reset();
      rst_n = 1'b0;
      instr_valid_d = 1'b0;
      #1;
      check("rst_regwrite_m", 32'(regwrite_m), 32'd0);
      check("rst_memwrite_m", 32'(memwrite_m), 32'd0);
      check("rst_regwrite_w", 32'(regwrite_w), 32'd0);
      check("rst_rd_m", 32'(rd_m), 32'd0);
      check("rst_rd_w", 32'(rd_w), 32'd0);
      check("rst_alucontrol_e", 32'(alucontrol_e), 32'd0);
      check("rst_jalr_e", 32'(jalr_e), 32'd0);
      check("rst_pcsrc_e", 32'(pcsrc_e), 32'd0);
      check("rst_stall_f", 32'(stall_f), 32'd0);
      check("rst_flush_e", 32'(flush_e), 32'd0);
      e_m = bub; m_m = bub; w_m = bub;
      fd = '{default: 0};
      fetchq.delete();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b1; instr_valid_d = 1'b0; op_d = '0; funct3_d = '0; funct75_d = 1'b0;
      rs1_d = '0; rs2_d = '0; rd_d = '0; zero_e = 1'b0; lt_e = 1'b0; ltu_e = 1'b0;
      zf = 0; ltf = 0; ltuf = 0; rand_flags = 0;
      #2;
      apply_reset();

      // add x3,x1,x2 then sub x4,x1,x2
      fetchq.push_back(mk(OP_R, 0, 0, 3, 1, 2));
      fetchq.push_back(mk(OP_R, 0, 1, 4, 1, 2));
      drain();

      // lw x5,0(x1) then dependent add x6,x5,x2
      fetchq.push_back(mk(OP_LD, 2, 0, 5, 1, 0));
      fetchq.push_back(mk(OP_R, 0, 0, 6, 5, 2));
      drain();

      // bne with zero_e=0 (taken), then with zero_e=1 (not taken)
      for (int z = 0; z < 2; z++) begin
         zf = 1'(z);
         fetchq.push_back(mk(OP_BR, 1, 0, 0, 1, 2));
         fetchq.push_back(mk(OP_R, 0, 0, 7, 1, 2));
         fetchq.push_back(mk(OP_R, 0, 0, 8, 1, 2));
         fetchq.push_back(mk(OP_R, 0, 0, 9, 1, 2));
         drain();
      end

      // bltu / bgeu / blt with lt_e=0, ltu_e=1
      zf = 0; ltf = 0; ltuf = 1;
      fetchq.push_back(mk(OP_BR, 6, 0, 0, 1, 2));
      fetchq.push_back(mk(OP_R, 0, 0, 10, 1, 2));
      fetchq.push_back(mk(OP_BR, 7, 0, 0, 1, 2));
      fetchq.push_back(mk(OP_R, 0, 0, 11, 1, 2));
      fetchq.push_back(mk(OP_BR, 4, 0, 0, 1, 2));
      fetchq.push_back(mk(OP_R, 0, 0, 12, 1, 2));
      drain();

      // jalr, lui, shifts, store, illegal opcode and illegal branch funct3
      fetchq.push_back(mk(OP_JALR, 0, 0, 1, 2, 0));
      fetchq.push_back(mk(OP_R, 0, 0, 13, 1, 2));
      fetchq.push_back(mk(OP_LUI, 0, 0, 10, 0, 0));
      fetchq.push_back(mk(OP_I, 5, 1, 14, 1, 0));
      fetchq.push_back(mk(OP_R, 5, 0, 15, 1, 2));
      fetchq.push_back(mk(OP_ST, 2, 0, 0, 1, 2));
      fetchq.push_back(mk(7'b1111111, 0, 0, 11, 1, 2));
      fetchq.push_back(mk(OP_BR, 2, 0, 0, 1, 2));
      fetchq.push_back(mk(OP_JAL, 0, 0, 1, 0, 0));
      fetchq.push_back(mk(OP_R, 0, 0, 16, 1, 2));
      drain();

      // reset with writes in flight in E, M and W
      for (int k = 0; k < 5; k++) fetchq.push_back(mk(OP_R, 0, 0, 20 + k, 1, 2));
      repeat (4) step();
      apply_reset();

      rand_flags = 1;
      for (int k = 0; k < 300; k++) fetchq.push_back(rand_ins());
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
